// File: rtl/util_mon_pkg.sv
// Shared types and helpers for the utilization monitor blocks.
package util_mon_pkg;

  typedef enum logic {IDLE, ACTIVE} util_state_e;

  localparam int unsigned DROP_W = 8;

  // Increment val when en is set, holding at the all-ones value of a width-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width,
                                          input logic en);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (en && (val != max_val)) ? val + 64'd1 : val;
  endfunction

endpackage

// File: rtl/util_rec_fifo.sv
// Synchronous record FIFO; a push into a full FIFO is accepted when a pop happens the same cycle.
module util_rec_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW:0]                 wr_ptr_q, rd_ptr_q;
  logic                        pop_ok, push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/util_mon_counter.sv
// Per-layer utilization accumulator: counts lane-valid and DMA-busy cycles over each layer
// window and queues one record per layer.
module util_mon_counter
  import util_mon_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 9,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDX_W      = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       dataflow_en,
  input  logic [NUM_LANES-1:0]       conv_vld,
  input  logic                       dma_start,
  input  logic                       dma_last,
  input  logic                       weight_dma_start,
  input  logic                       weight_dma_last,
  input  logic                       layer_start,
  input  logic                       layer_done,
  input  logic                       sim_done,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [IDX_W-1:0]           rec_idx,
  output logic [CNT_W-1:0]           rec_cycles,
  output logic [NUM_LANES*CNT_W-1:0] rec_lane_cnt,
  output logic [CNT_W-1:0]           rec_dma_cycles,
  output logic [CNT_W-1:0]           rec_wdma_cycles,
  output logic                       rec_trunc,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic                       proto_err
);

  localparam int unsigned LANE_LO = 2 * CNT_W + 1;
  localparam int unsigned CYC_LO  = LANE_LO + NUM_LANES * CNT_W;
  localparam int unsigned IDX_LO  = CYC_LO + CNT_W;
  localparam int unsigned REC_W   = IDX_LO + IDX_W;

  util_state_e                       state_q;
  logic [CNT_W-1:0]                  cycles_q, dma_cnt_q, wdma_cnt_q;
  logic [NUM_LANES-1:0][CNT_W-1:0]   lane_q;
  logic [CNT_W-1:0]                  cycles_inc, dma_inc, wdma_inc;
  logic [NUM_LANES-1:0][CNT_W-1:0]   lane_inc;
  logic                              dma_busy_q, wdma_busy_q;
  logic [IDX_W-1:0]                  layer_idx_q;
  logic [DROP_W-1:0]                 drop_cnt_q;
  logic                              proto_err_q;
  logic                              fresh, counting, close, restart, dropped;
  logic                              fifo_full, fifo_empty;
  logic [REC_W-1:0]                  rec_d, rec_head;

  // A window opening this cycle counts from zero regardless of stale register contents.
  assign fresh    = (state_q == IDLE);
  assign counting = (state_q == ACTIVE) || layer_start;
  assign close    = counting && (layer_done || sim_done);
  assign restart  = (state_q == ACTIVE) && layer_start && layer_done;
  assign dropped  = close && fifo_full && !(rec_valid && rec_ready);

  always_comb begin
    cycles_inc = CNT_W'(sat_inc(64'(fresh ? '0 : cycles_q), CNT_W, 1'b1));
    dma_inc    = CNT_W'(sat_inc(64'(fresh ? '0 : dma_cnt_q), CNT_W, dma_busy_q | dma_start));
    wdma_inc   = CNT_W'(sat_inc(64'(fresh ? '0 : wdma_cnt_q), CNT_W,
                                wdma_busy_q | weight_dma_start));
    lane_inc   = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      lane_inc[i] = CNT_W'(sat_inc(64'(fresh ? '0 : lane_q[i]), CNT_W,
                                   dataflow_en & conv_vld[i]));
    end
  end

  assign rec_d = {layer_idx_q, cycles_inc, lane_inc, dma_inc, wdma_inc, sim_done & ~layer_done};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cycles_q    <= '0;
      dma_cnt_q   <= '0;
      wdma_cnt_q  <= '0;
      lane_q      <= '0;
      dma_busy_q  <= 1'b0;
      wdma_busy_q <= 1'b0;
      layer_idx_q <= '0;
      drop_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (dma_start && !dma_last) dma_busy_q <= 1'b1;
      else if (dma_last)          dma_busy_q <= 1'b0;
      if (weight_dma_start && !weight_dma_last) wdma_busy_q <= 1'b1;
      else if (weight_dma_last)                 wdma_busy_q <= 1'b0;

      if (close)   layer_idx_q <= layer_idx_q + IDX_W'(1);
      if (dropped) drop_cnt_q  <= DROP_W'(sat_inc(64'(drop_cnt_q), DROP_W, 1'b1));
      if ((state_q == ACTIVE) && layer_start && !layer_done) proto_err_q <= 1'b1;

      if (restart) begin
        cycles_q   <= '0;
        dma_cnt_q  <= '0;
        wdma_cnt_q <= '0;
        lane_q     <= '0;
      end else if (close) begin
        state_q <= IDLE;
      end else if (counting) begin
        state_q    <= ACTIVE;
        cycles_q   <= cycles_inc;
        dma_cnt_q  <= dma_inc;
        wdma_cnt_q <= wdma_inc;
        lane_q     <= lane_inc;
      end
    end
  end

  util_rec_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (close),
    .push_data (rec_d),
    .pop       (rec_ready),
    .head      (rec_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rec_valid       = !fifo_empty;
  assign rec_idx         = rec_head[IDX_LO +: IDX_W];
  assign rec_cycles      = rec_head[CYC_LO +: CNT_W];
  assign rec_lane_cnt    = rec_head[LANE_LO +: NUM_LANES * CNT_W];
  assign rec_dma_cycles  = rec_head[CNT_W + 1 +: CNT_W];
  assign rec_wdma_cycles = rec_head[1 +: CNT_W];
  assign rec_trunc       = rec_head[0];
  assign drop_cnt        = drop_cnt_q;
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_util_mon_counter.sv
// Scoreboard bench: a wide-counter and a 4-bit-counter instance share stimulus; expected records
// are queued at layer close and checked by per-instance monitors when the head is accepted.
module tb_util_mon_counter;

  typedef struct packed {
    logic [15:0]      idx;
    logic [31:0]      cyc;
    logic [8:0][31:0] lanes;
    logic [31:0]      dma;
    logic [31:0]      wdma;
    logic             trunc;
  } rec_t;

  logic clk = 1'b0;
  logic rstn, dataflow_en, dma_start, dma_last, weight_dma_start, weight_dma_last;
  logic layer_start, layer_done, sim_done, rec_ready;
  logic [8:0] conv_vld;

  logic        rec_valid, rec_trunc, proto_err;
  logic [15:0] rec_idx;
  logic [31:0] rec_cycles, rec_dma_cycles, rec_wdma_cycles;
  logic [287:0] rec_lane_cnt;
  logic [7:0]  drop_cnt;

  logic        s_rec_valid, s_rec_trunc, s_proto_err;
  logic [15:0] s_rec_idx;
  logic [3:0]  s_rec_cycles, s_rec_dma_cycles, s_rec_wdma_cycles;
  logic [35:0] s_rec_lane_cnt;
  logic [7:0]  s_drop_cnt;

  rec_t q_big[$], q_small[$];
  rec_t got_b, exp_b, got_s, exp_s;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  util_mon_counter u_big (
    .clk (clk), .rstn (rstn), .dataflow_en (dataflow_en), .conv_vld (conv_vld),
    .dma_start (dma_start), .dma_last (dma_last), .weight_dma_start (weight_dma_start),
    .weight_dma_last (weight_dma_last), .layer_start (layer_start), .layer_done (layer_done),
    .sim_done (sim_done), .rec_valid (rec_valid), .rec_ready (rec_ready), .rec_idx (rec_idx),
    .rec_cycles (rec_cycles), .rec_lane_cnt (rec_lane_cnt), .rec_dma_cycles (rec_dma_cycles),
    .rec_wdma_cycles (rec_wdma_cycles), .rec_trunc (rec_trunc), .drop_cnt (drop_cnt),
    .proto_err (proto_err)
  );

  util_mon_counter #(.CNT_W (4)) u_small (
    .clk (clk), .rstn (rstn), .dataflow_en (dataflow_en), .conv_vld (conv_vld),
    .dma_start (dma_start), .dma_last (dma_last), .weight_dma_start (weight_dma_start),
    .weight_dma_last (weight_dma_last), .layer_start (layer_start), .layer_done (layer_done),
    .sim_done (sim_done), .rec_valid (s_rec_valid), .rec_ready (rec_ready),
    .rec_idx (s_rec_idx), .rec_cycles (s_rec_cycles), .rec_lane_cnt (s_rec_lane_cnt),
    .rec_dma_cycles (s_rec_dma_cycles), .rec_wdma_cycles (s_rec_wdma_cycles),
    .rec_trunc (s_rec_trunc), .drop_cnt (s_drop_cnt), .proto_err (s_proto_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic rec_t mk(input int idx, input int cyc, input logic [8:0] mask,
                              input int lv, input int dma, input int wdma, input logic tr);
    rec_t r;
    r.idx  = 16'(idx);
    r.cyc  = 32'(cyc);
    for (int i = 0; i < 9; i++) r.lanes[i] = mask[i] ? 32'(lv) : 32'd0;
    r.dma  = 32'(dma);
    r.wdma = 32'(wdma);
    r.trunc = tr;
    return r;
  endfunction

  function automatic logic [31:0] sat15(input logic [31:0] v);
    return (v > 32'd15) ? 32'd15 : v;
  endfunction

  task automatic push_exp(input rec_t r);
    rec_t s;
    q_big.push_back(r);
    s = r;
    s.cyc  = sat15(r.cyc);
    s.dma  = sat15(r.dma);
    s.wdma = sat15(r.wdma);
    for (int i = 0; i < 9; i++) s.lanes[i] = sat15(r.lanes[i]);
    q_small.push_back(s);
  endtask

  task automatic cmp_rec(input string tag, input rec_t g, input rec_t e);
    check({tag, "_idx"}, 64'(g.idx), 64'(e.idx));
    check({tag, "_cycles"}, 64'(g.cyc), 64'(e.cyc));
    check({tag, "_dma"}, 64'(g.dma), 64'(e.dma));
    check({tag, "_wdma"}, 64'(g.wdma), 64'(e.wdma));
    check({tag, "_trunc"}, 64'(g.trunc), 64'(e.trunc));
    for (int i = 0; i < 9; i++)
      check($sformatf("%s_lane%0d", tag, i), 64'(g.lanes[i]), 64'(e.lanes[i]));
  endtask

  always @(negedge clk) begin
    if (rstn && rec_valid && rec_ready) begin
      if (q_big.size() == 0) begin
        n_checks++;
        $display("FAIL big_unexpected_rec: got idx %0d, expected no record", rec_idx);
      end else begin
        exp_b = q_big.pop_front();
        got_b.idx = rec_idx; got_b.cyc = rec_cycles; got_b.dma = rec_dma_cycles;
        got_b.wdma = rec_wdma_cycles; got_b.trunc = rec_trunc;
        for (int i = 0; i < 9; i++) got_b.lanes[i] = rec_lane_cnt[i*32 +: 32];
        cmp_rec("big", got_b, exp_b);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && s_rec_valid && rec_ready) begin
      if (q_small.size() == 0) begin
        n_checks++;
        $display("FAIL small_unexpected_rec: got idx %0d, expected no record", s_rec_idx);
      end else begin
        exp_s = q_small.pop_front();
        got_s.idx = s_rec_idx; got_s.cyc = 32'(s_rec_cycles); got_s.dma = 32'(s_rec_dma_cycles);
        got_s.wdma = 32'(s_rec_wdma_cycles); got_s.trunc = s_rec_trunc;
        for (int i = 0; i < 9; i++) got_s.lanes[i] = 32'(s_rec_lane_cnt[i*4 +: 4]);
        cmp_rec("small", got_s, exp_s);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    layer_start = 1'b0; layer_done = 1'b0; sim_done = 1'b0;
    dma_start = 1'b0; dma_last = 1'b0; weight_dma_start = 1'b0; weight_dma_last = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_valid"}, 64'(rec_valid), 64'd0);
    check({tag, "_idx"}, 64'(rec_idx), 64'd0);
    check({tag, "_cycles"}, 64'(rec_cycles), 64'd0);
    check({tag, "_lanes"}, 64'(|rec_lane_cnt), 64'd0);
    check({tag, "_dma"}, 64'(rec_dma_cycles | rec_wdma_cycles), 64'd0);
    check({tag, "_trunc"}, 64'(rec_trunc), 64'd0);
    check({tag, "_drop"}, 64'(drop_cnt), 64'd0);
    check({tag, "_proto"}, 64'(proto_err), 64'd0);
    check({tag, "_s_valid"}, 64'(s_rec_valid | s_proto_err | (|s_drop_cnt)), 64'd0);
  endtask

  initial begin
    rstn = 1'b0; rec_ready = 1'b0; dataflow_en = 1'b0; conv_vld = '0;
    layer_start = 1'b0; layer_done = 1'b0; sim_done = 1'b0;
    dma_start = 1'b0; dma_last = 1'b0; weight_dma_start = 1'b0; weight_dma_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rstn = 1'b1;
    tick();

    // Overflow: six 3-cycle layers with no consumer; idx 4 and 5 are dropped.
    dataflow_en = 1'b1;
    for (int l = 0; l < 6; l++) begin
      conv_vld = 9'(1 << l);
      for (int k = 0; k < 3; k++) begin
        layer_start = (k == 0);
        layer_done  = (k == 2);
        if (k == 2 && l < 4) push_exp(mk(l, 3, 9'(1 << l), 3, 0, 0, 1'b0));
        tick();
      end
    end
    check("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    check("ovf_valid", 64'(rec_valid), 64'd1);

    // FIFO still full, but a pop in the closing cycle frees a slot for idx 6.
    conv_vld = '0;
    layer_start = 1'b1; tick();
    layer_done = 1'b1; rec_ready = 1'b1; push_exp(mk(6, 2, 9'h000, 0, 0, 0, 1'b0)); tick();
    rec_ready = 1'b0;
    check("full_pop_drop_cnt", 64'(drop_cnt), 64'd2);
    rec_ready = 1'b1;
    repeat (5) tick();
    rec_ready = 1'b0;
    check("drained_valid", 64'(rec_valid), 64'd0);

    // Single 20-cycle layer with lane activity and DMA bursts; weight burst spans layer_done.
    for (int k = 0; k < 20; k++) begin
      layer_start = (k == 0);
      layer_done  = (k == 19);
      dataflow_en = (k >= 5 && k <= 14);
      conv_vld = (k >= 5 && k <= 14) ? 9'h1FF : ((k == 16 || k == 17) ? 9'h0F0 : 9'h000);
      dma_start = (k == 2 || k == 10);
      dma_last  = (k == 6 || k == 10);
      weight_dma_start = (k == 15);
      if (k == 19) begin
        check("latency_before", 64'(rec_valid), 64'd0);
        push_exp(mk(7, 20, 9'h1FF, 10, 6, 5, 1'b0));
      end
      tick();
    end
    check("latency_after", 64'(rec_valid), 64'd1);
    weight_dma_last = 1'b1; tick();
    check("hold_idx", 64'(rec_idx), 64'd7);
    rec_ready = 1'b1; tick();

    // Back-to-back windows at k=4, lone start at k=8.
    conv_vld = 9'h1FF;
    for (int k = 0; k < 11; k++) begin
      if (k == 5) check("b2b_no_proto", 64'(proto_err), 64'd0);
      if (k == 9) check("lone_start_proto", 64'(proto_err), 64'd1);
      layer_start = (k == 0 || k == 4 || k == 8);
      layer_done  = (k == 4 || k == 10);
      dataflow_en = (k >= 2 && k <= 6);
      if (k == 4)  push_exp(mk(8, 5, 9'h1FF, 3, 0, 0, 1'b0));
      if (k == 10) push_exp(mk(9, 6, 9'h1FF, 2, 0, 0, 1'b0));
      tick();
    end
    dataflow_en = 1'b0; conv_vld = '0;
    repeat (2) tick();

    // 20-cycle layer closed by sim_done; the 4-bit instance saturates at 15.
    dataflow_en = 1'b1; conv_vld = 9'h1FF;
    for (int k = 0; k < 20; k++) begin
      layer_start = (k == 0);
      sim_done    = (k == 19);
      dma_start   = (k == 0);
      if (k == 19) push_exp(mk(10, 20, 9'h1FF, 20, 20, 0, 1'b1));
      tick();
    end
    dataflow_en = 1'b0; conv_vld = '0;
    dma_last = 1'b1; tick();
    repeat (2) tick();

    // Reset mid-layer with two records queued and a DMA burst open.
    rec_ready = 1'b0;
    layer_start = 1'b1; layer_done = 1'b1; tick();
    layer_start = 1'b1; layer_done = 1'b1; tick();
    check("pre_reset_valid", 64'(rec_valid), 64'd1);
    layer_start = 1'b1; dma_start = 1'b1; weight_dma_start = 1'b1; tick();
    tick();
    rstn = 1'b0;
    #2;
    chk_zero("mid_reset");
    tick();
    rstn = 1'b1;
    tick();
    layer_start = 1'b1; layer_done = 1'b1; push_exp(mk(0, 1, 9'h000, 0, 0, 0, 1'b0)); tick();
    rec_ready = 1'b1;
    repeat (2) tick();

    check("big_queue_empty", 64'(q_big.size()), 64'd0);
    check("small_queue_empty", 64'(q_small.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/util_mon_counter.md
# util_mon_counter

Per-layer utilization accumulator for the conv dataflow engine. It generalises the passive utilization probe into an active counter block with a parametrised lane count, counter width and record-FIFO depth. Per-lane conv-valid cycles and DMA busy cycles are counted across each `layer_start`..`layer_done` window. One record per layer is pushed into a small FIFO, which the testbench or a debug bus drains over a valid/ready port.

## Interface
- `NUM_LANES`, 9, conv lanes monitored (width of `conv_vld`)
- `CNT_W`, 32, width of every cycle counter; counters saturate
- `FIFO_DEPTH`, 4, record FIFO entries; power of two, ≥2
- `IDX_W`, 16, layer index width; wraps modulo 2^IDX_W
- `clk`  in  1  sole clock; all logic on posedge
- `rstn`  in  1  asynchronous, active-low reset
- `dataflow_en`  in  1  qualifies lane counting
- `conv_vld`  in  NUM_LANES  per-lane valid
- `dma_start` / `dma_last`  in  1  output-writer DMA burst bounds
- `weight_dma_start` / `weight_dma_last`  in  1  weight DMA burst bounds
- `layer_start` / `layer_done`  in  1  layer window bounds (1-cycle pulses)
- `sim_done`  in  1  forces truncation of an open layer
- `rec_valid`  out  1  FIFO head valid
- `rec_ready`  in  1  consumer accepts head
- `rec_idx`  out  IDX_W  layer index of head record
- `rec_cycles`  out  CNT_W  total window cycles
- `rec_lane_cnt`  out  NUM_LANES*CNT_W  lane i in bits [i*CNT_W +: CNT_W]
- `rec_dma_cycles`, `rec_wdma_cycles`  out  CNT_W  DMA busy cycles
- `rec_trunc`  out  1  record closed by `sim_done`
- `drop_cnt`  out  8  records lost to full FIFO (saturating)
- `proto_err`  out  1  sticky; `layer_start` while ACTIVE

## Operation
- FSM has two states: IDLE and ACTIVE. Reset state is IDLE.
- IDLE → ACTIVE on `layer_start`. The live counters clear, and the start cycle counts as cycle 1.
- In ACTIVE, every cycle does the following:
  - `cycles` increments.
  - Lane i increments when `dataflow_en & conv_vld[i]`.
  - `dma_cycles` increments when `dma_busy | dma_start`.
  - `wdma_cycles` increments likewise for the weight DMA.
- `dma_busy` is set by `dma_start` and cleared by `dma_last`. The last cycle is counted. Start and last in the same cycle is a 1-cycle burst. Busy tracking runs in both states, but counting happens only in ACTIVE.
- ACTIVE → IDLE on `layer_done` or `sim_done`. The closing cycle is included in the counts, and the record is pushed.
  - `rec_trunc` = `sim_done & ~layer_done`.
  - `layer_idx` increments after every close, including dropped records.
- `layer_start` and `layer_done` in the same cycle while in ACTIVE: the current record closes and includes this cycle. The FSM stays ACTIVE. The new layer's counters start at 0 and count from the next cycle.
- `layer_start` in ACTIVE without `layer_done`: ignored, and `proto_err` is set.
- `layer_done` or `sim_done` in IDLE: ignored.
- `layer_start` and `layer_done` in the same cycle while in IDLE: opens and immediately closes a 1-cycle record.
- Counters saturate at 2^CNT_W−1 and never wrap.
- FIFO full at push time:
  - If `rec_valid & rec_ready` in the same cycle, the pop frees a slot and the push succeeds.
  - Otherwise the record is dropped and `drop_cnt` increments.
- Asserting `rstn` low mid-layer does the following:
  - Discards the open layer and clears the FIFO.
  - Clears `layer_idx`, `drop_cnt` and `proto_err`.
  - Clears `dma_busy` and the weight-DMA busy flag.

## Timing
- Reset values: every output is 0, the FIFO is empty and the state is IDLE.
- Push latency: a record closed in cycle N shows `rec_valid`=1 in cycle N+1 if the FIFO was empty.
- `rec_*` come straight from the FIFO head register, with no combinational path from the inputs.
- Pop happens on a posedge with `rec_valid & rec_ready`. The next head appears the following cycle.
- `rec_*` hold stable while `rec_valid & ~rec_ready`.
- `rec_ready` may be asserted while `rec_valid`=0 and has no effect.
- `proto_err` and `drop_cnt` are registered. They update in the cycle after the triggering event.

## Structure
- Package `util_mon_pkg` holds:
  - the state enum `util_state_e` {IDLE, ACTIVE};
  - the `drop_cnt` width localparam (8);
  - the saturating-increment function `sat_inc`.
- The record is a packed vector assembled in the top module, because its width depends on parameters.
- Sub-module `util_rec_fifo`: synchronous FIFO parametrised by width and depth.
  - It provides registered head output, `full`/`empty` flags and simultaneous push/pop when full.
  - It is reused for other monitor records.
- Expected size is roughly 250 RTL lines.

## Test plan
- **Single layer:** `layer_start` at cycle 10 and `layer_done` at cycle 29. `conv_vld`=9'h1FF with `dataflow_en`=1 during cycles 15..24.
  - Required: `rec_cycles`=20, each lane=10, `rec_idx`=0, `rec_valid` at cycle 30.
- **DMA bursts:** `dma_start`@12/`dma_last`@16, plus start and last in the same cycle @20.
  - Required: `rec_dma_cycles`=6. A burst spanning `layer_done` is counted only up to `layer_done`.
- **FIFO overflow:** `FIFO_DEPTH`=4, 6 layers closed with `rec_ready`=0.
  - Required: 4 records with idx 0..3, `drop_cnt`=2. The next record gets idx 6.
- **Back-to-back windows:** `layer_start` and `layer_done` in the same cycle while in ACTIVE; also a lone `layer_start` while in ACTIVE.
  - Required: two records with correct counts, `proto_err`=1 only for the lone start.
- **Saturation and truncation:** `CNT_W`=4, an 20-cycle layer, then `sim_done`.
  - Required: `rec_cycles`=15 and `rec_trunc`=1.
- **Reset mid-layer:** `rstn` low during ACTIVE with 2 records queued.
  - Required: all outputs 0 and `rec_valid`=0. The next layer gets idx 0.
